shift_unit: RTL
===============

# shift_unit

Parametrised, pipelined barrel shift unit for the datapath ALU. It supports five modes: logical left, logical right, arithmetic right, rotate left and rotate right. Operands enter through a valid/ready handshake and pass through log2(WIDTH) mux stages with optional inter-stage registers. Results leave through a matching valid/ready handshake with zero and carry-out flags, so the unit can stall against a busy writeback without losing data.

## Interface

Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 4.
- PIPELINED, 0. When 0, one register at the output only (latency 1). When 1, a register after every mux stage (latency S = log2(WIDTH)).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_a  in  WIDTH  value to shift.
- in_amt  in  log2(WIDTH)  shift/rotate amount, unsigned.
- in_op  in  3  000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR; 101–111 illegal.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_zero  out  1  out_data == 0.
- out_carry  out  1  last bit shifted out. Always 0 for rotates, for amt == 0 and for illegal ops.
- out_illegal  out  1  beat carried an illegal op.

## Operation

- Beat accepted when in_valid && in_ready. Result delivered when out_valid && out_ready.
- Stage k (k = 0..S-1) shifts by 2^k when amt[k] = 1, otherwise passes the value through.
- Fill bits by mode:
  - SHL and SHR: zeros.
  - SHRA: copies of in_a[WIDTH-1], captured at input and carried down the pipe.
  - ROL and ROR: the bits shifted out of the opposite end.
- Carry:
  - SHL: in_a[WIDTH-amt].
  - SHR and SHRA: in_a[amt-1].
  - Carry is computed stage-by-stage: each active stage updates carry with the last bit it displaces.
- Illegal op: out_data = in_a unchanged, out_carry = 0, out_illegal = 1. out_zero is still computed from out_data.
- Each pipeline register holds data, the remaining amt bits, op, sign, carry and a valid bit.
- Register r advances when it is empty, or when register r+1 advances or is empty. The last register advances when out_ready is high.
- in_ready = !v0 || advance0, where v0 is the first register's valid bit. in_ready is combinational from out_ready through the advance chain; there is no skid buffer.
- Bubbles collapse: an empty register accepts new data even while downstream is stalled.
- Reset (rst_n = 0 at a rising edge): all valid bits are 0. out_data, out_zero, out_carry and out_illegal are 0. in_ready reads 1 on the first cycle after reset deasserts.
- Reset mid-operation discards every in-flight beat; no partial result is ever presented.

## Timing

- Latency from accept edge to out_valid: 1 cycle when PIPELINED = 0, S cycles when PIPELINED = 1 (5 for WIDTH = 32).
- Throughput: one beat per cycle while out_ready is held high.
- out_* change only on a rising clk edge. They stay stable while out_valid && !out_ready.
- Simultaneous accept at the input and deliver at the output in the same cycle is allowed when the pipe is full. The occupancy count is unchanged.
- Max in-flight beats: 1 when PIPELINED = 0, S when PIPELINED = 1. in_ready drops exactly when all registers are valid and out_ready = 0.
- The amt = 0 path still takes the full latency.

## Test plan

- WIDTH = 32, PIPELINED = 0:
  - SHL 0x80000001 amt 1 → out_data 0x00000002, carry 1, zero 0.
  - SHR 0x80000000 amt 4 → 0x08000000, carry 0.
  - SHRA 0x80000000 amt 4 → 0xF8000000.
  - SHRA 0x7FFFFFFF amt 31 → 0x00000000, zero 1, carry 1.
- Rotates:
  - ROL 0x80000001 amt 1 → 0x00000003, carry 0.
  - ROR 0x00000001 amt 1 → 0x80000000.
  - ROL x amt 0 → x, for random x.
  - in_op = 111 → in_a returned, illegal 1.
- PIPELINED = 1, stream of 20 random beats with out_ready = 1:
  - first out_valid exactly 5 cycles after the first accept;
  - one result per cycle, in order, matching the reference model.
- Backpressure: hold out_ready = 0 after 5 accepts.
  - in_ready = 0 with the pipe full; out_data stable.
  - Raise out_ready: all 5 results delivered in order, no loss and no duplication.
  - Then random out_ready toggling on a 200-beat stream: nothing lost or duplicated, order preserved.
- Reset mid-stream: assert rst_n = 0 for one cycle with 3 beats in flight.
  - Next cycle: out_valid = 0, all outputs 0, in_ready = 1.
  - None of the 3 in-flight beats ever appears at the output.
- WIDTH = 8, PIPELINED = 1: SHRA 0x90 amt 3 → 0xF2, latency 3; ROR 0x01 amt 7 → 0x02.

Source files
------------

// File: rtl/shift_unit.sv
// Pipelined barrel shifter: SHL/SHR/SHRA/ROL/ROR over log2(WIDTH) mux stages,
// valid/ready at both ends, with optional registers between every stage.
module shift_unit #(
  parameter int WIDTH     = 32,
  parameter bit PIPELINED = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [2:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic                     out_carry,
  output logic                     out_illegal
);
  localparam int AW   = $clog2(WIDTH);
  localparam int S    = AW;
  localparam int NREG = PIPELINED ? S : 1;

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHRA = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    amt;
    logic [2:0]       op;
    logic             sign;
    logic             carry;
  } stage_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             carry;
    logic             illegal;
  } res_t;

  // One mux stage: shift by 2^k when amt[k] is set; carry tracks the last
  // bit this stage pushes off the end. Illegal ops fall through untouched.
  function automatic stage_t shift_stage(input stage_t s, input int k);
    stage_t           r;
    logic [WIDTH-1:0] lo, hi, msk;
    logic [AW-1:0]    a;
    int               n;
    n   = 1 << k;
    r   = s;
    a   = s.amt >> k;
    lo  = s.data >> (n - 1);
    hi  = s.data >> (WIDTH - n);
    msk = ~({WIDTH{1'b1}} >> n);
    if (a[0]) begin
      case (s.op)
        OP_SHL:  begin r.data = s.data << n; r.carry = hi[0]; end
        OP_SHR:  begin r.data = s.data >> n; r.carry = lo[0]; end
        OP_SHRA: begin r.data = (s.data >> n) | ({WIDTH{s.sign}} & msk); r.carry = lo[0]; end
        OP_ROL:  r.data = (s.data << n) | (s.data >> (WIDTH - n));
        OP_ROR:  r.data = (s.data >> n) | (s.data << (WIDTH - n));
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic res_t to_res(input stage_t s);
    res_t r;
    r.data    = s.data;
    r.zero    = (s.data == '0);
    r.carry   = s.carry;
    r.illegal = (s.op > OP_ROR);
    return r;
  endfunction

  stage_t          beat_in;
  res_t            res_d, res_q;
  logic [NREG-1:0] vld_q, vin, adv;

  assign beat_in = '{data: in_a, amt: in_amt, op: in_op, sign: in_a[WIDTH-1], carry: 1'b0};

  always_comb begin
    vin    = '0;
    vin[0] = in_valid;
    for (int r = 1; r < NREG; r++) vin[r] = vld_q[r-1];
  end

  // Advance chain runs back from the output; an empty slot always advances,
  // which lets bubbles collapse while the consumer stalls.
  always_comb begin : adv_chain
    logic a;
    adv        = '0;
    a          = !vld_q[NREG-1] || out_ready;
    adv[NREG-1] = a;
    for (int r = NREG - 2; r >= 0; r--) begin
      a      = !vld_q[r] || a;
      adv[r] = a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      res_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        if (adv[r]) vld_q[r] <= vin[r];
      if (adv[NREG-1] && vin[NREG-1]) res_q <= res_d;
    end
  end

  if (PIPELINED) begin : g_pipe
    stage_t mid_q [S-1];
    stage_t mid_d [S-1];

    always_comb begin
      mid_d[0] = shift_stage(beat_in, 0);
      for (int k = 1; k < S - 1; k++) mid_d[k] = shift_stage(mid_q[k-1], k);
      res_d = to_res(shift_stage(mid_q[S-2], S - 1));
    end

    // Payload only moves with a valid beat; stale contents behind a clear
    // valid bit are never observed.
    always_ff @(posedge clk) begin
      for (int r = 0; r < S - 1; r++)
        if (adv[r] && vin[r]) mid_q[r] <= mid_d[r];
    end
  end else begin : g_flat
    always_comb begin : chain
      stage_t s;
      s = beat_in;
      for (int k = 0; k < S; k++) s = shift_stage(s, k);
      res_d = to_res(s);
    end
  end

  assign in_ready    = adv[0];
  assign out_valid   = vld_q[NREG-1];
  assign out_data    = res_q.data;
  assign out_zero    = res_q.zero;
  assign out_carry   = res_q.carry;
  assign out_illegal = res_q.illegal;
endmodule
